// File: rtl/mem_model_req.sv
// mem_model_req: behavioural word memory with a valid/ready request channel,
// configurable read latency, byte-enabled writes, an in-order response queue
// with credit-based backpressure, and out-of-range request counting.
// Optional trace output is enabled by defining MEM_MODEL_REQ_TRACE_EN.
module mem_model_req #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_WORDS  = 65536,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [31:0]         err_count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [63:0]      MEM_WORDS_L = 64'(MEM_WORDS);
  localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(RSP_DEPTH);

  // Backing store; left unreset so a testbench can preload it hierarchically.
  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic [CNT_W-1:0]  r_outstanding;
  logic [31:0]       r_errCount;
  logic [DATA_W-1:0] r_fifoData [RSP_DEPTH];
  logic              r_fifoErr  [RSP_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_fifoCount;

  logic              w_inRange;
  logic [IDX_W-1:0]  w_idx;
  logic              w_accept;
  logic              w_rdAccept;
  logic              w_pop;
  logic [DATA_W-1:0] w_rdData;
  logic              w_pushValid;
  logic [DATA_W-1:0] w_pushData;
  logic              w_pushErr;

  assign w_inRange  = (64'(req_addr) < MEM_WORDS_L);
  assign w_idx      = IDX_W'(req_addr);
  assign req_ready  = !rst && (r_outstanding < DEPTH_C);
  assign w_accept   = req_valid && req_ready;
  assign w_rdAccept = w_accept && !req_we;
  assign w_rdData   = w_inRange ? mem[w_idx] : '0;

  assign rsp_valid  = (r_fifoCount != '0);
  assign rsp_rdata  = rsp_valid ? r_fifoData[r_rdPtr] : '0;
  assign rsp_err    = rsp_valid && r_fifoErr[r_rdPtr];
  assign w_pop      = rsp_valid && rsp_ready;
  assign err_count  = r_errCount;

  // Byte-lane writes; out-of-range writes are dropped without touching memory.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && w_inRange) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) begin
          mem[w_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Credit counter: a read reserves a queue slot at accept, a handshake frees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
    end else if (w_rdAccept && !w_pop) begin
      r_outstanding <= r_outstanding + CNT_W'(1);
    end else if (!w_rdAccept && w_pop) begin
      r_outstanding <= r_outstanding - CNT_W'(1);
    end
  end

  // Saturating count of every out-of-range request, reads and writes alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_errCount <= '0;
    end else if (w_accept && !w_inRange && (r_errCount != 32'hFFFF_FFFF)) begin
      r_errCount <= r_errCount + 32'd1;
    end
  end

  // The accept edge already counts as one cycle of latency, so only
  // RD_LATENCY-1 delay stages sit between the memory read and the queue.
  generate
    if (RD_LATENCY == 1) begin : g_noPipe
      assign w_pushValid = w_rdAccept;
      assign w_pushData  = w_rdData;
      assign w_pushErr   = w_rdAccept && !w_inRange;
    end else begin : g_pipe
      localparam int PIPE_N = RD_LATENCY - 1;
      logic [PIPE_N-1:0] r_pipeValid;
      logic [PIPE_N-1:0] r_pipeErr;
      logic [DATA_W-1:0] r_pipeData [PIPE_N];

      // Shift read results down the latency pipeline; reset drops in-flight reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pipeValid <= '0;
          r_pipeErr   <= '0;
          for (int i = 0; i < PIPE_N; i++) begin
            r_pipeData[i] <= '0;
          end
        end else begin
          r_pipeValid[0] <= w_rdAccept;
          r_pipeErr[0]   <= w_rdAccept && !w_inRange;
          r_pipeData[0]  <= w_rdData;
          for (int i = 1; i < PIPE_N; i++) begin
            r_pipeValid[i] <= r_pipeValid[i-1];
            r_pipeErr[i]   <= r_pipeErr[i-1];
            r_pipeData[i]  <= r_pipeData[i-1];
          end
        end
      end

      assign w_pushValid = r_pipeValid[PIPE_N-1];
      assign w_pushData  = r_pipeData[PIPE_N-1];
      assign w_pushErr   = r_pipeErr[PIPE_N-1];
    end
  endgenerate

  // Queue payload storage; entries are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (w_pushValid) begin
      r_fifoData[r_wrPtr] <= w_pushData;
      r_fifoErr[r_wrPtr]  <= w_pushErr;
    end
  end

  // Queue pointers and occupancy; credits guarantee a push never finds it full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_fifoCount <= '0;
    end else begin
      if (w_pushValid) begin
        r_wrPtr <= (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + PTR_W'(1);
      end
      if (w_pushValid && !w_pop) begin
        r_fifoCount <= r_fifoCount + CNT_W'(1);
      end else if (!w_pushValid && w_pop) begin
        r_fifoCount <= r_fifoCount - CNT_W'(1);
      end
    end
  end

`ifdef MEM_MODEL_REQ_TRACE_EN
  // Trace every accepted request and every response handshake.
  always @(posedge clk) begin
    if (w_accept) begin
      $display("%0t mem_model_req %s addr=%h data=%h be=%h", $time,
               req_we ? "W" : "R", req_addr, req_wdata, req_be);
    end
    if (!rst && w_pop) begin
      $display("%0t mem_model_req RSP data=%h err=%b", $time, rsp_rdata, rsp_err);
    end
  end
`else
  // Trace disabled: the model produces no simulation output.
`endif

endmodule

// File: tb/tb_mem_model_req.sv
// tb_mem_model_req: table-driven vectors and directed sequences for
// mem_model_req, checked cycle by cycle against a scoreboard model.
module tb_mem_model_req;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int WORDS = 256;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int NV    = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [31:0]   err_count;

  mem_model_req #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(WORDS), .RD_LATENCY(LAT), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          readyEdge;
  } rsp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expData;
    bit          expErr;
  } vec_t;

  rsp_t        sbQ[$];
  vec_t        vecs [NV];
  logic [31:0] modelMem [WORDS];
  int          modelOut = 0;
  int          modelErr = 0;
  int          edgeCount = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit headReady();
    if (sbQ.size() == 0) return 1'b0;
    return (sbQ[0].readyEdge <= edgeCount);
  endfunction

  task automatic checkOutput();
    bit expValid;
    expValid = headReady();
    checkEq("req_ready", 32'(req_ready), 32'(modelOut < DEPTH));
    checkEq("rsp_valid", 32'(rsp_valid), 32'(expValid));
    if (expValid) begin
      checkEq("rsp_rdata", rsp_rdata, sbQ[0].data);
      checkEq("rsp_err", 32'(rsp_err), 32'(sbQ[0].err));
    end
    checkEq("err_count", err_count, 32'(modelErr));
  endtask

  task automatic applyStimulus(input bit v, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input bit rspRdy, input bit useExp,
                               input logic [31:0] expData, input bit expErr,
                               output bit accepted);
    bit   expReady;
    bit   expValid;
    bit   inRange;
    rsp_t r;
    @(negedge clk);
    checkOutput();
    req_valid = v;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = rspRdy;
    expReady  = (modelOut < DEPTH);
    expValid  = headReady();
    accepted  = v && expReady;
    @(posedge clk);
    edgeCount++;
    if (expValid && rspRdy) begin
      void'(sbQ.pop_front());
      modelOut--;
    end
    inRange = (addr < WORDS);
    if (accepted) begin
      if (!inRange) modelErr++;
      if (we) begin
        if (inRange) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) modelMem[addr[7:0]][b*8 +: 8] = wdata[b*8 +: 8];
          end
        end
      end else begin
        r.data      = useExp ? expData : (inRange ? modelMem[addr[7:0]] : 32'h0);
        r.err       = useExp ? expErr : !inRange;
        r.readyEdge = edgeCount + LAT - 1;
        sbQ.push_back(r);
        modelOut++;
      end
    end
  endtask

  task automatic idle(input int n, input bit rspRdy);
    bit acc;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rspRdy, 1'b0, 32'h0, 1'b0, acc);
    end
  endtask

  initial begin
    bit acc;
    int nextAddr;
    int validCount;

    vecs[0]  = '{1'b1, 32'd5,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'd5,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'd7,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'd7,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[4]  = '{1'b1, 32'd7,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'd7,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[6]  = '{1'b0, 32'd256, 32'h0,        4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 32'd259, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'd3,   32'h0,        4'h0, 32'h10000303, 1'b0};
    vecs[9]  = '{1'b1, 32'd2,   32'hCAFEF00D, 4'h2, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'd2,   32'h0,        4'h0, 32'h1000F002, 1'b0};

    for (int i = 0; i < WORDS; i++) modelMem[i] = 32'h0;

    // Reset values while rst is held high.
    #12;
    checkEq("rst_req_ready", 32'(req_ready), 32'h0);
    checkEq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkEq("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkEq("rst_rsp_err", 32'(rsp_err), 32'h0);
    checkEq("rst_err_count", err_count, 32'h0);

    // Preload a small window of memory through the hierarchy.
    for (int i = 0; i < 16; i++) begin
      modelMem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    end
    modelMem[7] = 32'h11223344;
    for (int i = 0; i < 16; i++) dut.mem[i] = modelMem[i];

    @(negedge clk);
    rst = 1'b0;
    #1;
    checkEq("release_req_ready", 32'(req_ready), 32'h1);

    // Table-driven writes and reads with known results.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                    1'b1, !vecs[i].we, vecs[i].expData, vecs[i].expErr, acc);
    end
    idle(LAT + 3, 1'b1);
    #1;
    checkEq("err_count_two", err_count, 32'd2);

    // Backpressure: six reads with rsp_ready low, only DEPTH fit.
    nextAddr = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(nextAddr < 6, 1'b0, 32'(nextAddr), 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0, acc);
      if (acc) nextAddr++;
    end
    #1;
    checkEq("bp_ready_low", 32'(req_ready), 32'h0);
    checkEq("bp_rsp_held", 32'(rsp_valid), 32'h1);
    for (int c = 0; c < 40 && (nextAddr < 6 || sbQ.size() > 0); c++) begin
      applyStimulus(nextAddr < 6, 1'b0, 32'(nextAddr), 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, acc);
      if (acc) nextAddr++;
    end
    idle(2, 1'b1);

    // Streaming reads with rsp_ready high: one response per cycle.
    validCount = 0;
    for (int c = 0; c < 26; c++) begin
      applyStimulus(1'b1, 1'b0, 32'(c % 16), 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, acc);
      #1;
      if (c >= 6 && rsp_valid) validCount++;
    end
    checkEq("stream_rsp_count", 32'(validCount), 32'd20);
    idle(LAT + 2, 1'b1);

    // Reset with three reads in flight discards them immediately.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, 32'(c + 1), 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b0, acc);
    end
    #2;
    rst = 1'b1;
    req_valid = 1'b0;
    #1;
    checkEq("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkEq("async_rst_req_ready", 32'(req_ready), 32'h0);
    checkEq("async_rst_err_count", err_count, 32'h0);
    sbQ.delete();
    modelOut = 0;
    modelErr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkEq("rerelease_req_ready", 32'(req_ready), 32'h1);
    idle(10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
